nonce_sweeper: RTL and testbench
================================

NONCE_SWEEPER -- requirements
Module: nonce_sweeper

Interface
REQ-001 Parameter NONCE_OFFSET, default 19: word offset of the nonce within the 20-word message.
REQ-002 Parameter DIGEST_WORDS, default 8: number of digest words read back.
REQ-003 clk  in  1  clock.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 message_addr, output_addr  in  16 each  base addresses of message block and digest in shared memory.
REQ-007 nonce_start, nonce_count  in  32 each  first nonce and number of nonces to try.
REQ-008 target  in  256  threshold; target[255:224] aligns with digest word 0.
REQ-009 sha_start  out  1  one-cycle start pulse to the SHA-256 core.
REQ-010 sha_done  in  1  SHA core done level: high when idle, low while hashing.
REQ-011 mem_sel  out  1  high when this block owns the memory port; low while the SHA core runs.
REQ-012 mem_we  out  1; mem_addr  out  16; mem_write_data  out  32; mem_read_data  in  32.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at sweep end.
REQ-015 found  out  1; found_nonce  out  32; hash_count  out  32 (hashes completed in the current sweep).

Function
REQ-016 States SHALL be IDLE, WRNONCE, KICK, WAITLO, WAITHI, READ, CHECK, FINISH.
REQ-017 IDLE: on start, latch all inputs, set nonce=nonce_start, remaining=nonce_count, and clear found, found_nonce, hash_count; go to FINISH if nonce_count==0, else WRNONCE.
REQ-018 WRNONCE (1 cycle): mem_sel=1, mem_we=1, mem_addr=message_addr+NONCE_OFFSET, mem_write_data=nonce; next KICK.
REQ-019 KICK (1 cycle): mem_we=0, sha_start=1, mem_sel=0; next WAITLO.
REQ-020 WAITLO: hold until sha_done==0, then WAITHI; WAITHI: hold until sha_done==1, then READ with mem_sel=1.
REQ-021 Memory SHALL have 1-cycle read latency: mem_read_data reflects the mem_addr registered at the previous rising edge.
REQ-022 READ: issue mem_addr=output_addr+i for i=0..7 on consecutive cycles; consume word i one cycle after it is issued; READ lasts 9 cycles.
REQ-023 Comparison is streaming and lexicographic, word 0 most significant: a 2-bit status starts at EQ and latches LT or GT at the first unequal word; later words are ignored.
REQ-024 CHECK (1 cycle): hash_count increments by 1.
REQ-025 CHECK, status LT: found=1, found_nonce=nonce, next FINISH.
REQ-026 CHECK, status not LT (EQ counts as not found): remaining decrements, nonce increments modulo 2^32; next FINISH if remaining becomes 0, else WRNONCE.
REQ-027 FINISH (1 cycle): done=1, mem_sel=0; next IDLE.
REQ-028 found, found_nonce and hash_count SHALL hold their values until the next accepted start.
REQ-029 start outside IDLE SHALL be ignored; input changes after acceptance SHALL have no effect.
REQ-030 Per-nonce overhead excluding SHA time SHALL be 2 + 9 + 1 = 12 cycles plus the WAITLO/WAITHI durations.
REQ-031 mem_we SHALL be high only in WRNONCE.
REQ-032 While mem_sel=0, mem_we SHALL be 0.

Reset
REQ-033 reset_n low SHALL force, asynchronously: state IDLE; sha_start, mem_we, mem_sel, busy, done, found all 0; mem_addr, mem_write_data, found_nonce, hash_count all 0.
REQ-034 Reset mid-sweep SHALL abandon the sweep with no further memory writes; the next start after release SHALL behave as a fresh sweep.

Verification
REQ-035 nonce_count=0, start -> done pulse 2 cycles later; found=0; hash_count=0; no mem_we, no sha_start.
REQ-036 Stub digest all 0xFFFFFFFF, target=0x0000FFFF followed by 0s, nonce_start=5, count=3 -> writes of 5, 6, 7 to message_addr+19; 3 sha_start pulses; done; found=0; hash_count=3.
REQ-037 Stub digest word0=0x00000001 (rest 0) only when nonce==0x10, else all 0xFF; target word0=0x00000002 (rest 0); start=0x0E, count=10 -> found=1, found_nonce=0x10, hash_count=3, no 4th sha_start.
REQ-038 Digest exactly equal to target, count=1 -> found=0, hash_count=1.
REQ-039 nonce_start=0xFFFFFFFE, count=3, no hit -> nonce writes 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-040 Assert reset_n low during WAITHI of the 2nd nonce -> all outputs at reset values immediately; a subsequent start with count=1 completes normally with hash_count=1.

Source files
------------

// File: rtl/nonce_sweeper.sv
// nonce_sweeper: walks a range of nonces through an external SHA-256 core.
// Each nonce is written into the message block, the core is kicked, and the
// digest is streamed back and compared against a 256-bit target.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   start                    one-cycle sweep request (taken only when idle)
//   message_addr/output_addr message block / digest base addresses
//   nonce_start/nonce_count  first nonce and number of nonces to try
//   target                   threshold, target[255:224] vs digest word 0
//   sha_start/sha_done       SHA core kick pulse / done level
//   mem_sel/mem_we/mem_addr  shared memory port (owned while mem_sel=1)
//   mem_write_data/mem_read_data  memory data, 1-cycle read latency
//   busy/done                not idle / end-of-sweep pulse
//   found/found_nonce        hit flag and winning nonce
//   hash_count               hashes completed in this sweep
module nonce_sweeper #(
   parameter int NONCE_OFFSET = 19,
   parameter int DIGEST_WORDS = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [15:0]  message_addr,
   input  logic [15:0]  output_addr,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_count,
   input  logic [255:0] target,
   output logic         sha_start,
   input  logic         sha_done,
   output logic         mem_sel,
   output logic         mem_we,
   output logic [15:0]  mem_addr,
   output logic [31:0]  mem_write_data,
   input  logic [31:0]  mem_read_data,
   output logic         busy,
   output logic         done,
   output logic         found,
   output logic [31:0]  found_nonce,
   output logic [31:0]  hash_count
);

   typedef enum logic [2:0] {
      IDLE, WRNONCE, KICK, WAITLO, WAITHI, READ, CHECK, FINISH
   } state_t;

   localparam logic [1:0]  CMP_EQ  = 2'd0;
   localparam logic [1:0]  CMP_LT  = 2'd1;
   localparam logic [1:0]  CMP_GT  = 2'd2;
   localparam logic [3:0]  RD_LAST = 4'(DIGEST_WORDS);
   localparam logic [15:0] NOFS    = 16'(NONCE_OFFSET);

   state_t        state_q, state_d;
   logic [15:0]   msg_addr_q, out_addr_q;
   logic [255:0]  target_q;
   logic [31:0]   nonce_q, remaining_q;
   logic [3:0]    rd_cnt_q;
   logic [1:0]    cmp_q;
   logic [2:0]    widx;
   logic [31:0]   tgt_word;

   // Word consumed in READ lags the issued address by one cycle.
   assign widx = 3'(rd_cnt_q - 4'd1);

   always_comb begin
      tgt_word = '0;
      for (int i = 0; i < 8; i++) begin
         if (widx == 3'(i)) tgt_word = target_q[255-32*i -: 32];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      sha_start      = 1'b0;
      mem_sel        = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      done           = 1'b0;
      busy           = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (start)
               state_d = (nonce_count == '0) ? FINISH : WRNONCE;
         end
         WRNONCE: begin
            mem_sel        = 1'b1;
            mem_we         = 1'b1;
            mem_addr       = msg_addr_q + NOFS;
            mem_write_data = nonce_q;
            state_d        = KICK;
         end
         KICK: begin
            sha_start = 1'b1;
            state_d   = WAITLO;
         end
         WAITLO: begin
            if (!sha_done) state_d = WAITHI;
         end
         WAITHI: begin
            if (sha_done) state_d = READ;
         end
         READ: begin
            mem_sel = 1'b1;
            if (rd_cnt_q != RD_LAST)
               mem_addr = out_addr_q + {12'd0, rd_cnt_q};
            else
               state_d = CHECK;
         end
         CHECK: begin
            if (cmp_q == CMP_LT || remaining_q == 32'd1)
               state_d = FINISH;
            else
               state_d = WRNONCE;
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         msg_addr_q  <= '0;
         out_addr_q  <= '0;
         target_q    <= '0;
         nonce_q     <= '0;
         remaining_q <= '0;
         rd_cnt_q    <= '0;
         cmp_q       <= CMP_EQ;
         found       <= 1'b0;
         found_nonce <= '0;
         hash_count  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  msg_addr_q  <= message_addr;
                  out_addr_q  <= output_addr;
                  target_q    <= target;
                  nonce_q     <= nonce_start;
                  remaining_q <= nonce_count;
                  found       <= 1'b0;
                  found_nonce <= '0;
                  hash_count  <= '0;
               end
            end
            WAITHI: begin
               if (sha_done) begin
                  rd_cnt_q <= '0;
                  cmp_q    <= CMP_EQ;
               end
            end
            READ: begin
               rd_cnt_q <= rd_cnt_q + 4'd1;
               // First unequal word decides; later words are ignored.
               if (rd_cnt_q != 4'd0 && cmp_q == CMP_EQ) begin
                  if (mem_read_data < tgt_word)
                     cmp_q <= CMP_LT;
                  else if (mem_read_data > tgt_word)
                     cmp_q <= CMP_GT;
               end
            end
            CHECK: begin
               hash_count <= hash_count + 32'd1;
               if (cmp_q == CMP_LT) begin
                  found       <= 1'b1;
                  found_nonce <= nonce_q;
               end else begin
                  remaining_q <= remaining_q - 32'd1;
                  nonce_q     <= nonce_q + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nonce_sweeper.sv
// tb_nonce_sweeper: directed-vector bench with a memory model, a SHA stub
// and a queue scoreboard checking nonce writes and sweep results.
module tb_nonce_sweeper;

   localparam logic [15:0] MSG = 16'h0010;
   localparam logic [15:0] OUT = 16'h0080;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic        f;
      logic [31:0] fn;
      logic [31:0] hc;
      int          shas;
   } res_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [15:0]  message_addr = MSG;
   logic [15:0]  output_addr = OUT;
   logic [31:0]  nonce_start = '0;
   logic [31:0]  nonce_count = '0;
   logic [255:0] target = '0;
   logic         sha_start;
   logic         sha_done;
   logic         mem_sel, mem_we;
   logic [15:0]  mem_addr;
   logic [31:0]  mem_write_data, mem_read_data;
   logic         busy, done, found;
   logic [31:0]  found_nonce, hash_count;

   int n_vec = 0;
   int n_miss = 0;
   int mode = 0;

   wr_t  exp_wr[$];
   res_t exp_res[$];

   logic [31:0] mem [0:255];
   logic [31:0] dig [0:7];
   logic [15:0] rd_addr_q;
   logic        stub_wr;

   localparam logic [255:0] T_FFFF = {32'h0000FFFF, 224'h0};
   localparam logic [255:0] T_TWO  = {32'h00000002, 224'h0};
   localparam logic [255:0] T_PAT  = {32'h00000003, 32'h11111111,
      32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555,
      32'h66666666, 32'h77777777};

   nonce_sweeper dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .message_addr(message_addr), .output_addr(output_addr),
      .nonce_start(nonce_start), .nonce_count(nonce_count),
      .target(target), .sha_start(sha_start), .sha_done(sha_done),
      .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .busy(busy), .done(done), .found(found),
      .found_nonce(found_nonce), .hash_count(hash_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_sel && mem_we) mem[mem_addr[7:0]] <= mem_write_data;
      if (stub_wr)
         for (int i = 0; i < 8; i++) mem[OUT[7:0] + 8'(i)] <= dig[i];
      rd_addr_q <= mem_addr;
   end
   assign mem_read_data = mem[rd_addr_q[7:0]];

   function automatic logic [31:0] dig_word(input int md,
                                            input logic [31:0] n,
                                            input int i);
      case (md)
         1: return (n == 32'h10) ? ((i == 0) ? 32'h1 : 32'h0)
                                 : 32'hFFFFFFFF;
         2: return (i == 0) ? 32'h3 : 32'(i) * 32'h11111111;
         3: return (i == 0) ? 32'h3 :
                   (i == 1) ? 32'h11111110 : 32'hFFFFFFFF;
         4: return (i == 0) ? 32'h1 : 32'hFFFFFFFF;
         default: return 32'hFFFFFFFF;
      endcase
   endfunction

   // SHA stub: drops sha_done, fills the digest, raises sha_done.
   initial begin
      logic [31:0] n;
      sha_done = 1'b1;
      stub_wr  = 1'b0;
      forever begin
         @(negedge clk);
         if (sha_start) begin
            n = mem[MSG[7:0] + 8'd19];
            sha_done = 1'b0;
            for (int i = 0; i < 8; i++) dig[i] = dig_word(mode, n, i);
            repeat (4) @(negedge clk);
            stub_wr = 1'b1;
            @(negedge clk);
            stub_wr  = 1'b0;
            sha_done = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Monitor: pops expected writes and results as the DUT presents them.
   initial begin
      int  shas;
      wr_t w;
      res_t r;
      shas = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            shas = 0;
         end else begin
            if (sha_start) shas++;
            if (mem_we) begin
               chk("we_needs_sel", 32'(mem_sel), 32'd1);
               if (exp_wr.size() == 0) begin
                  chk("unexpected_write", mem_write_data, 32'hxxxxxxxx);
               end else begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", 32'(mem_addr), 32'(w.addr));
                  chk("wr_data", mem_write_data, w.data);
               end
            end
            if (done) begin
               if (exp_res.size() == 0) begin
                  chk("unexpected_done", 32'(done), 32'd0);
               end else begin
                  r = exp_res.pop_front();
                  chk("found", 32'(found), 32'(r.f));
                  chk("found_nonce", found_nonce, r.fn);
                  chk("hash_count", hash_count, r.hc);
                  chk("sha_starts", 32'(shas), 32'(r.shas));
               end
               shas = 0;
            end
         end
      end
   end

   task automatic push_writes(input logic [31:0] ns, input int k);
      for (int i = 0; i < k; i++)
         exp_wr.push_back('{MSG + 16'd19, ns + 32'(i)});
   endtask

   task automatic run_sweep(input logic [31:0] ns, input logic [31:0] nc,
                            input logic [255:0] tg, input int md,
                            input logic poke);
      int cyc;
      mode = md;
      message_addr = MSG;
      output_addr = OUT;
      nonce_start = ns;
      nonce_count = nc;
      target = tg;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      if (poke) begin
         repeat (3) @(negedge clk);
         nonce_start  = 32'hDEAD0000;
         nonce_count  = 32'd0;
         target       = '0;
         message_addr = 16'h0040;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         cyc += 4;
      end
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) chk("done_timeout", 32'(done), 32'd1);
      if (nc == 0) chk("zero_count_latency", 32'(cyc <= 2), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      int seen, cyc;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_sel", 32'(mem_sel), 32'd0);
      chk("rst_hash_count", hash_count, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      exp_res.push_back('{1'b0, 32'h0, 32'd0, 0});
      run_sweep(32'h5, 32'd0, T_FFFF, 0, 1'b0);

      push_writes(32'h5, 3);
      exp_res.push_back('{1'b0, 32'h0, 32'd3, 3});
      run_sweep(32'h5, 32'd3, T_FFFF, 0, 1'b0);

      push_writes(32'hE, 3);
      exp_res.push_back('{1'b1, 32'h10, 32'd3, 3});
      run_sweep(32'hE, 32'd10, T_TWO, 1, 1'b0);
      repeat (3) @(negedge clk);
      nonce_start = 32'h0;
      chk("found_hold", 32'(found), 32'd1);
      chk("found_nonce_hold", found_nonce, 32'h10);

      push_writes(32'h100, 1);
      exp_res.push_back('{1'b0, 32'h0, 32'd1, 1});
      run_sweep(32'h100, 32'd1, T_PAT, 2, 1'b0);

      push_writes(32'h7, 1);
      exp_res.push_back('{1'b1, 32'h7, 32'd1, 1});
      run_sweep(32'h7, 32'd2, T_PAT, 3, 1'b0);

      push_writes(32'hFFFFFFFE, 3);
      exp_res.push_back('{1'b0, 32'h0, 32'd3, 3});
      run_sweep(32'hFFFFFFFE, 32'd3, T_FFFF, 0, 1'b0);

      push_writes(32'h30, 1);
      exp_res.push_back('{1'b1, 32'h30, 32'd1, 1});
      run_sweep(32'h30, 32'd2, T_TWO, 4, 1'b1);

      // Abandon a sweep with reset while the 2nd hash is in flight.
      push_writes(32'h20, 2);
      mode = 0;
      message_addr = MSG;
      output_addr = OUT;
      nonce_start = 32'h20;
      nonce_count = 32'd3;
      target = T_FFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      cyc = 0;
      while (seen < 2 && cyc < 500) begin
         @(negedge clk);
         if (sha_start) seen++;
         cyc++;
      end
      chk("second_kick_seen", 32'(seen), 32'd2);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_done", 32'(done), 32'd0);
      chk("ar_sha_start", 32'(sha_start), 32'd0);
      chk("ar_mem_we", 32'(mem_we), 32'd0);
      chk("ar_mem_sel", 32'(mem_sel), 32'd0);
      chk("ar_found", 32'(found), 32'd0);
      chk("ar_mem_addr", 32'(mem_addr), 32'd0);
      chk("ar_wdata", mem_write_data, 32'd0);
      chk("ar_found_nonce", found_nonce, 32'd0);
      chk("ar_hash_count", hash_count, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      push_writes(32'h40, 1);
      exp_res.push_back('{1'b0, 32'h0, 32'd1, 1});
      run_sweep(32'h40, 32'd1, T_FFFF, 0, 1'b0);

      repeat (5) @(negedge clk);
      chk("leftover_writes", 32'(exp_wr.size()), 32'd0);
      chk("leftover_results", 32'(exp_res.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
